// File: rtl/m_pte_port.sv
// m_pte_port: single-outstanding PTE read/write-back responder bridging MMU walks onto the DRAM arbiter.
// Optional one-entry PTE buffer enabled by defining PTE_PORT_BUF_EN.
module m_pte_port #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 1023,
    parameter int CNT_W   = 10
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_pte_req,
    input  logic              i_pte_we,
    input  logic [ADDR_W-1:0] i_pte_addr,
    input  logic [31:0]       i_pte_wdata,
    input  logic              i_flush,
    output logic              o_busy,
    output logic [31:0]       o_rdata,
    output logic              o_done,
    output logic              o_err,
    output logic              o_dram_req,
    output logic              o_dram_we,
    output logic [ADDR_W-1:0] o_dram_addr,
    output logic [31:0]       o_dram_wdata,
    input  logic              i_dram_ack,
    input  logic [31:0]       i_dram_rdata
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state;
    logic [CNT_W-1:0] cnt;
    // last WAIT cycle: counter would reach TIMEOUT on this edge
    logic last;
    assign last = (cnt == CNT_W'(TIMEOUT - 1));
`ifdef PTE_PORT_BUF_EN
    logic              buf_valid;
    logic [ADDR_W-1:0] buf_addr;
    logic [31:0]       buf_data;
    logic              buf_match;
    assign buf_match = buf_valid && (buf_addr == i_pte_addr);
`else
    logic unused_flush;
    assign unused_flush = i_flush;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            cnt          <= '0;
            o_busy       <= 1'b0;
            o_rdata      <= '0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
            o_dram_req   <= 1'b0;
            o_dram_we    <= 1'b0;
            o_dram_addr  <= '0;
            o_dram_wdata <= '0;
`ifdef PTE_PORT_BUF_EN
            buf_valid    <= 1'b0;
            buf_addr     <= '0;
            buf_data     <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (i_pte_req) begin
`ifdef PTE_PORT_BUF_EN
                    if (i_pte_we && buf_match) buf_data <= i_pte_wdata;
                    if (!i_pte_we && buf_match) begin
                        o_rdata <= buf_data;
                        o_done  <= 1'b1;
                        state   <= RESP;
                    end else
`endif
                    begin
                        o_dram_we    <= i_pte_we;
                        o_dram_addr  <= i_pte_addr;
                        o_dram_wdata <= i_pte_wdata;
                        o_busy       <= 1'b1;
                        o_dram_req   <= 1'b1;
                        cnt          <= '0;
                        state        <= WAIT;
                    end
                end
                WAIT: begin
                    if (i_dram_ack) begin
                        if (!o_dram_we) begin
                            o_rdata <= i_dram_rdata;
`ifdef PTE_PORT_BUF_EN
                            buf_valid <= 1'b1;
                            buf_addr  <= o_dram_addr;
                            buf_data  <= i_dram_rdata;
`endif
                        end
                        o_dram_req <= 1'b0;
                        o_busy     <= 1'b0;
                        o_done     <= 1'b1;
                        state      <= RESP;
                    end else if (last) begin
                        o_err      <= 1'b1;
                        o_rdata    <= '0;
                        o_dram_req <= 1'b0;
                        o_busy     <= 1'b0;
                        o_done     <= 1'b1;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    o_done <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
`ifdef PTE_PORT_BUF_EN
            // placed last so a flush overrides a same-cycle fill
            if (i_flush) buf_valid <= 1'b0;
`endif
        end
    end
endmodule

// File: tb/tb_m_pte_port.sv
// tb_m_pte_port: directed checks of m_pte_port handshake, timeout, reset and optional buffer.
module tb_m_pte_port;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        i_pte_req = 1'b0, i_pte_we = 1'b0, i_flush = 1'b0, i_dram_ack = 1'b0;
    logic [31:0] i_pte_addr = '0, i_pte_wdata = '0, i_dram_rdata = '0;
    logic        o_busy, o_done, o_err, o_dram_req, o_dram_we;
    logic [31:0] o_rdata, o_dram_addr, o_dram_wdata;
    int checks = 0;
    int failures = 0;

    m_pte_port dut (
        .CLK(CLK), .RST(RST), .i_pte_req(i_pte_req), .i_pte_we(i_pte_we),
        .i_pte_addr(i_pte_addr), .i_pte_wdata(i_pte_wdata), .i_flush(i_flush),
        .o_busy(o_busy), .o_rdata(o_rdata), .o_done(o_done), .o_err(o_err),
        .o_dram_req(o_dram_req), .o_dram_we(o_dram_we), .o_dram_addr(o_dram_addr),
        .o_dram_wdata(o_dram_wdata), .i_dram_ack(i_dram_ack), .i_dram_rdata(i_dram_rdata)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        i_pte_req = 1'b1; i_pte_we = we; i_pte_addr = addr; i_pte_wdata = wdata;
        tick();
        i_pte_req = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst_busy", {31'b0, o_busy}, 0);
        chk("rst_done", {31'b0, o_done}, 0);
        chk("rst_err", {31'b0, o_err}, 0);
        chk("rst_req", {31'b0, o_dram_req}, 0);
        chk("rst_rdata", o_rdata, 0);
        chk("rst_addr", o_dram_addr, 0);
        tick(); tick();
        RST = 1'b0;
        tick();

        // read, ack in second WAIT cycle
        start(1'b0, 32'h8000_1004, 32'h0);
        chk("rd_busy", {31'b0, o_busy}, 1);
        chk("rd_req_w1", {31'b0, o_dram_req}, 1);
        chk("rd_addr", o_dram_addr, 32'h8000_1004);
        chk("rd_we", {31'b0, o_dram_we}, 0);
        chk("rd_done_w1", {31'b0, o_done}, 0);
        tick();
        chk("rd_req_w2", {31'b0, o_dram_req}, 1);
        i_dram_ack = 1'b1; i_dram_rdata = 32'h2000_0C01;
        tick();
        i_dram_ack = 1'b0; i_dram_rdata = '0;
        chk("rd_req_drop", {31'b0, o_dram_req}, 0);
        chk("rd_done", {31'b0, o_done}, 1);
        chk("rd_busy_fall", {31'b0, o_busy}, 0);
        chk("rd_data", o_rdata, 32'h2000_0C01);
        tick();
        chk("rd_done_once", {31'b0, o_done}, 0);

        // write-back, ack in first WAIT cycle
        start(1'b1, 32'h8000_1004, 32'h2000_0CC1);
        chk("wr_we", {31'b0, o_dram_we}, 1);
        chk("wr_wdata", o_dram_wdata, 32'h2000_0CC1);
        chk("wr_req", {31'b0, o_dram_req}, 1);
        i_dram_ack = 1'b1; i_dram_rdata = 32'hDEAD_BEEF;
        tick();
        i_dram_ack = 1'b0;
        chk("wr_done", {31'b0, o_done}, 1);
        chk("wr_rdata_kept", o_rdata, 32'h2000_0C01);
        tick();

        // request held high across a whole transaction
        i_pte_req = 1'b1; i_pte_we = 1'b0; i_pte_addr = 32'h8000_1008;
        tick();
        chk("hold_req", {31'b0, o_dram_req}, 1);
        tick();
        chk("hold_wait", {31'b0, o_busy}, 1);
        i_dram_ack = 1'b1; i_dram_rdata = 32'h1111_1111;
        tick();
        i_dram_ack = 1'b0;
        chk("hold_done", {31'b0, o_done}, 1);
        tick();
        chk("hold_no_dup", {31'b0, o_dram_req}, 0);
        chk("hold_idle_busy", {31'b0, o_busy}, 0);
        i_pte_req = 1'b0;
        chk("hold_data", o_rdata, 32'h1111_1111);

        // ack arriving in the last WAIT cycle beats the timeout
        start(1'b0, 32'h8000_2004, 32'h0);
        repeat (1022) tick();
        chk("edge_req", {31'b0, o_dram_req}, 1);
        i_dram_ack = 1'b1; i_dram_rdata = 32'h2222_3333;
        tick();
        i_dram_ack = 1'b0;
        chk("edge_err", {31'b0, o_err}, 0);
        chk("edge_data", o_rdata, 32'h2222_3333);
        chk("edge_done", {31'b0, o_done}, 1);
        tick();

        // timeout with no ack
        start(1'b0, 32'h8000_3000, 32'h0);
        repeat (1022) tick();
        chk("to_req_last", {31'b0, o_dram_req}, 1);
        chk("to_err_before", {31'b0, o_err}, 0);
        tick();
        chk("to_req_drop", {31'b0, o_dram_req}, 0);
        chk("to_err", {31'b0, o_err}, 1);
        chk("to_rdata", o_rdata, 0);
        chk("to_done", {31'b0, o_done}, 1);
        tick();
        start(1'b0, 32'h8000_3004, 32'h0);
        i_dram_ack = 1'b1; i_dram_rdata = 32'hABCD_0001;
        tick();
        i_dram_ack = 1'b0;
        chk("after_to_done", {31'b0, o_done}, 1);
        chk("after_to_data", o_rdata, 32'hABCD_0001);
        chk("err_sticky", {31'b0, o_err}, 1);
        tick();

        // spurious ack in IDLE
        i_dram_ack = 1'b1; i_dram_rdata = 32'h9999_9999;
        tick();
        i_dram_ack = 1'b0;
        chk("spur_done", {31'b0, o_done}, 0);
        chk("spur_data", o_rdata, 32'hABCD_0001);

        // reset during WAIT, then late ack
        start(1'b1, 32'h8000_4000, 32'h1234_5678);
        chk("mid_req", {31'b0, o_dram_req}, 1);
        RST = 1'b1;
        #1;
        chk("mid_rst_req", {31'b0, o_dram_req}, 0);
        chk("mid_rst_busy", {31'b0, o_busy}, 0);
        chk("mid_rst_err", {31'b0, o_err}, 0);
        chk("mid_rst_rdata", o_rdata, 0);
        chk("mid_rst_wdata", o_dram_wdata, 0);
        chk("mid_rst_we", {31'b0, o_dram_we}, 0);
        tick();
        RST = 1'b0;
        i_dram_ack = 1'b1; i_dram_rdata = 32'h7777_7777;
        tick();
        i_dram_ack = 1'b0;
        chk("late_ack_done", {31'b0, o_done}, 0);
        chk("late_ack_busy", {31'b0, o_busy}, 0);
        chk("late_ack_data", o_rdata, 0);
        tick();

`ifdef PTE_PORT_BUF_EN
        start(1'b0, 32'h8000_2000, 32'h0);
        i_dram_ack = 1'b1; i_dram_rdata = 32'h5555_AAAA;
        tick();
        i_dram_ack = 1'b0;
        chk("buf_fill_done", {31'b0, o_done}, 1);
        tick();
        start(1'b0, 32'h8000_2000, 32'h0);
        chk("buf_hit_done", {31'b0, o_done}, 1);
        chk("buf_hit_req", {31'b0, o_dram_req}, 0);
        chk("buf_hit_busy", {31'b0, o_busy}, 0);
        chk("buf_hit_data", o_rdata, 32'h5555_AAAA);
        tick();
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        start(1'b0, 32'h8000_2000, 32'h0);
        chk("buf_flush_req", {31'b0, o_dram_req}, 1);
        i_dram_ack = 1'b1; i_dram_rdata = 32'h6666_0000;
        tick();
        i_dram_ack = 1'b0;
        chk("buf_flush_data", o_rdata, 32'h6666_0000);
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/m_pte_port.md
Name: m_pte_port

Overview:
- Memory-side responder for MMU page-table-walk traffic.
- Accepts one PTE read (L1/L0 fetch) or PTE write-back (A/D update) at a time from the MMU. Converts it into a single DRAM-controller transaction and returns data with a busy/done handshake.
- Sits between the MMU's PTE address/access outputs and the DRAM arbiter.
- Supplies the MMU's `w_dram_busy` and `w_dram_odata` inputs.

Parameters:
- ADDR_W, 32, physical address width of PTE requests.
- TIMEOUT, 1023, DRAM ack timeout in cycles; minimum 1.
- CNT_W, 10, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous active-high reset.
- i_pte_req  in  1  MMU request strobe; sampled only in IDLE.
- i_pte_we  in  1  1 = PTE write-back, 0 = PTE read.
- i_pte_addr  in  ADDR_W  PTE physical address; must be word-aligned.
- i_pte_wdata  in  32  write-back data.
- i_flush  in  1  TLB flush (sfence.vma); used only by the optional buffer.
- o_busy  out  1  request in flight; drives MMU `w_dram_busy`.
- o_rdata  out  32  last read PTE; drives MMU `w_dram_odata`.
- o_done  out  1  one-cycle pulse when a transaction completes.
- o_err  out  1  sticky timeout flag.
- o_dram_req  out  1  DRAM request, held until ack.
- o_dram_we  out  1  DRAM write enable.
- o_dram_addr  out  ADDR_W  DRAM address.
- o_dram_wdata  out  32  DRAM write data.
- i_dram_ack  in  1  one-cycle completion pulse from DRAM.
- i_dram_rdata  in  32  read data, valid with i_dram_ack.

Behaviour:
- Reset (async, RST=1):
  - state=IDLE.
  - o_busy, o_done, o_err, o_dram_req, o_dram_we = 0.
  - o_rdata, o_dram_addr, o_dram_wdata = 0.
  - Timeout counter = 0; buffer invalid.
- IDLE:
  - If i_pte_req=1, capture addr/we/wdata into o_dram_*.
  - Set o_busy=1 and o_dram_req=1 on the next edge; go to WAIT.
  - Accept-to-busy latency is 1 cycle.
  - i_pte_req while not IDLE is ignored. No queueing; the MMU holds its request until it sees busy.
- WAIT:
  - o_dram_req stays high; o_dram_addr, o_dram_we and o_dram_wdata are stable.
  - Counter increments each cycle.
  - On i_dram_ack: drop o_dram_req and go to RESP. For a read, latch i_dram_rdata into o_rdata.
  - Ack in the same cycle the counter reaches TIMEOUT: the ack wins.
  - Counter reaches TIMEOUT without ack: set o_err=1, o_rdata=0, drop o_dram_req, go to RESP.
- RESP:
  - o_busy=0 and o_done=1 for exactly this one cycle; return to IDLE.
  - Minimum read turnaround: accept edge, then ack in the first WAIT cycle, then RESP = 3 cycles.
- o_rdata is held until the next read completes. Writes never modify o_rdata.
- o_err clears only on RST.
- An i_dram_ack outside WAIT is ignored.
- RST asserted mid-transaction: return immediately to IDLE with all outputs at reset values. A late ack after reset is ignored.
- The counter resets to 0 on every entry to WAIT.

Optional Feature:
- Macro: PTE_PORT_BUF_EN.
- When defined, a one-entry PTE buffer (addr, data, valid) is added:
  - Read hit in IDLE (valid and addr match): skip DRAM and go directly to RESP next cycle with o_rdata = buffered data. o_busy stays 0, o_done pulses.
  - Read miss: the completed DRAM read fills the buffer.
  - Write to the buffered address: updates the buffered data in the accept cycle; the write still goes to DRAM.
  - i_flush=1 clears valid in any state. Flush in the same cycle as a fill: flush wins.
- When undefined, every request goes to DRAM and i_flush is unused.

Test Plan:
- Read addr 0x8000_1004, DRAM acks 2 cycles after req with 0x2000_0C01 -> o_dram_req high 2 cycles, o_rdata=0x2000_0C01, o_done pulses once, o_busy falls on the o_done cycle.
- Write addr 0x8000_1004 data 0x2000_0CC1, ack after 1 cycle -> o_dram_we=1, o_dram_wdata=0x2000_0CC1, o_rdata unchanged.
- Read with no ack, TIMEOUT=1023 -> o_dram_req drops after 1023 WAIT cycles, o_err=1, o_rdata=0, o_done pulses; the next request still completes normally.
- RST pulsed during WAIT, then spurious ack -> all outputs return to reset values, state IDLE, ack ignored.
- i_pte_req held high through a whole transaction -> exactly one DRAM request per IDLE acceptance, no duplicate request.
- PTE_PORT_BUF_EN: read 0x8000_2000 twice -> second read has no o_dram_req and o_done 1 cycle after accept. Assert i_flush, read again -> DRAM request issued.
